mips_reg_wb_arbiter: RTL and testbench

Write-back arbiter and scoreboard for the single write port of the 32x32 MIPS register file. Three producers compete for the port through valid/ready handshakes: load unit, mult/div unit and ALU. Requests are arbitrated round-robin and drive RegWrite/WriteAddress/DataIn one cycle later. A per-register busy scoreboard lets issue logic reserve destinations and detect read-after-write hazards on the two read addresses.

---
 rtl/mips_reg_wb_arbiter.sv | 109 ++++++++++
 tb/tb_mips_reg_wb_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mips_reg_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mips_reg_wb_arbiter
// Brief    : Round-robin write-back arbiter and busy scoreboard for the MIPS
//            register file write port.
// Revision : 1.0 - initial release
// ============================================================================
module mips_reg_wb_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [2:0]                 req_valid,
   input  logic [2:0][ADDR_WIDTH-1:0] req_addr,
   input  logic [2:0][DATA_WIDTH-1:0] req_data,
   output logic [2:0]                 req_ready,
   output logic                       RegWrite,
   output logic [ADDR_WIDTH-1:0]      WriteAddress,
   output logic [DATA_WIDTH-1:0]      DataIn,
   input  logic                       reserve_valid,
   input  logic [ADDR_WIDTH-1:0]      reserve_addr,
   output logic                       reserve_ready,
   input  logic [ADDR_WIDTH-1:0]      Address1,
   input  logic [ADDR_WIDTH-1:0]      Address2,
   output logic                       hazard1,
   output logic                       hazard2,
   output logic [ADDR_WIDTH:0]        busy_count
);

   localparam int NREG = 1 << ADDR_WIDTH;

   logic [1:0]            ptr_q;
   logic                  regwrite_q;
   logic [ADDR_WIDTH-1:0] waddr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [NREG-1:0]       busy_q, busy_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;

   logic [1:0] ord0, ord1, ord2, gidx;
   logic       gnt_any, xfer;

   function automatic logic [1:0] nxt(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // Search begins at the requester after the last one granted.
   assign ord0 = nxt(ptr_q);
   assign ord1 = nxt(ord0);
   assign ord2 = nxt(ord1);

   always_comb begin
      gnt_any = 1'b1;
      gidx    = ord0;
      if (req_valid[ord0])      gidx = ord0;
      else if (req_valid[ord1]) gidx = ord1;
      else if (req_valid[ord2]) gidx = ord2;
      else                      gnt_any = 1'b0;
   end

   assign req_ready = (!rst && gnt_any) ? (3'b001 << gidx) : 3'b000;
   assign xfer      = |(req_valid & req_ready);

   assign reserve_ready = !rst && reserve_valid &&
                          ((reserve_addr == '0) || !busy_q[reserve_addr] ||
                           (regwrite_q && (waddr_q == reserve_addr)));

   // Clear from the retiring write first so a same-cycle reservation wins.
   always_comb begin
      busy_d = busy_q;
      if (regwrite_q)
         busy_d[waddr_q] = 1'b0;
      if (reserve_ready && (reserve_addr != '0))
         busy_d[reserve_addr] = 1'b1;
      busy_d[0] = 1'b0;
      count_d = '0;
      for (int i = 1; i < NREG; i++)
         count_d = count_d + {{ADDR_WIDTH{1'b0}}, busy_d[i]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q      <= 2'd2;
         regwrite_q <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= '0;
         busy_q     <= '0;
         count_q    <= '0;
      end else begin
         busy_q     <= busy_d;
         count_q    <= count_d;
         regwrite_q <= xfer && (req_addr[gidx] != '0);
         if (xfer) begin
            ptr_q   <= gidx;
            waddr_q <= req_addr[gidx];
            wdata_q <= req_data[gidx];
         end
      end
   end

   assign RegWrite     = regwrite_q;
   assign WriteAddress = waddr_q;
   assign DataIn       = wdata_q;
   assign busy_count   = count_q;
   assign hazard1      = busy_q[Address1] && (Address1 != '0);
   assign hazard2      = busy_q[Address2] && (Address2 != '0);

endmodule
`default_nettype wire

// File: tb/tb_mips_reg_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_reg_wb_arbiter
// Brief    : Directed-vector bench for the write-back arbiter and scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_reg_wb_arbiter;

   logic             clk = 1'b0;
   logic             rst;
   logic [2:0]       req_valid;
   logic [2:0][4:0]  req_addr;
   logic [2:0][31:0] req_data;
   logic [2:0]       req_ready;
   logic             RegWrite;
   logic [4:0]       WriteAddress;
   logic [31:0]      DataIn;
   logic             reserve_valid;
   logic [4:0]       reserve_addr;
   logic             reserve_ready;
   logic [4:0]       Address1, Address2;
   logic             hazard1, hazard2;
   logic [5:0]       busy_count;

   int total = 0;
   int bad   = 0;

   mips_reg_wb_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
      .req_ready(req_ready),
      .RegWrite(RegWrite), .WriteAddress(WriteAddress), .DataIn(DataIn),
      .reserve_valid(reserve_valid), .reserve_addr(reserve_addr),
      .reserve_ready(reserve_ready),
      .Address1(Address1), .Address2(Address2),
      .hazard1(hazard1), .hazard2(hazard2),
      .busy_count(busy_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [2:0] rr_exp [6];

   initial begin
      rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      rst = 1'b1; req_valid = 3'b111; req_addr = '0; req_data = '0;
      reserve_valid = 1'b1; reserve_addr = 5'd3; Address1 = '0; Address2 = '0;

      // Reset held two cycles with every requester valid
      tick(); tick();
      check("rst_ready", {29'd0, req_ready}, 32'h0);
      check("rst_resv_ready", {31'd0, reserve_ready}, 32'h0);
      check("rst_regwrite", {31'd0, RegWrite}, 32'h0);
      check("rst_busy_count", {26'd0, busy_count}, 32'h0);
      check("rst_waddr", {27'd0, WriteAddress}, 32'h0);
      rst = 1'b0; reserve_valid = 1'b0;
      #1 check("post_rst_ready", {29'd0, req_ready}, 32'h1);
      req_valid = 3'b000;

      // Single ALU write
      req_valid = 3'b100; req_addr[2] = 5'd5; req_data[2] = 32'hDEADBEEF;
      #1 check("single_ready", {29'd0, req_ready}, 32'h4);
      tick();
      req_valid = 3'b000;
      check("single_regwrite", {31'd0, RegWrite}, 32'h1);
      check("single_waddr", {27'd0, WriteAddress}, 32'd5);
      check("single_data", DataIn, 32'hDEADBEEF);
      tick();
      check("single_idle_regwrite", {31'd0, RegWrite}, 32'h0);
      check("single_hold_data", DataIn, 32'hDEADBEEF);

      // Round robin, all requesters valid (pointer last granted = 2)
      for (int i = 0; i < 3; i++) begin
         req_addr[i] = 5'(10 + i);
         req_data[i] = 32'h100 + i;
      end
      req_valid = 3'b111;
      for (int c = 0; c < 6; c++) begin
         #1 check($sformatf("rr_ready_%0d", c), {29'd0, req_ready}, {29'd0, rr_exp[c]});
         tick();
         check($sformatf("rr_waddr_%0d", c), {27'd0, WriteAddress}, 32'(10 + (c % 3)));
         check($sformatf("rr_data_%0d", c), DataIn, 32'h100 + (c % 3));
      end
      req_valid = 3'b000;
      tick();
      check("rr_idle_regwrite", {31'd0, RegWrite}, 32'h0);

      // Scoreboard: reserve r8, then load writes r8
      reserve_valid = 1'b1; reserve_addr = 5'd8; Address1 = 5'd8; Address2 = 5'd8;
      #1 check("resv8_ready", {31'd0, reserve_ready}, 32'h1);
      check("resv8_hazard_before", {31'd0, hazard1}, 32'h0);
      tick();
      reserve_valid = 1'b0;
      check("resv8_count", {26'd0, busy_count}, 32'd1);
      check("resv8_hazard1", {31'd0, hazard1}, 32'h1);
      reserve_valid = 1'b1;
      #1 check("resv8_again_ready", {31'd0, reserve_ready}, 32'h0);
      reserve_valid = 1'b0;
      tick();
      check("resv8_again_count", {26'd0, busy_count}, 32'd1);
      req_valid = 3'b001; req_addr[0] = 5'd8; req_data[0] = 32'h88;
      #1 check("load8_ready", {29'd0, req_ready}, 32'h1);
      tick();
      req_valid = 3'b000;
      check("load8_regwrite", {31'd0, RegWrite}, 32'h1);
      check("load8_hazard_wb", {31'd0, hazard1}, 32'h1);
      tick();
      check("load8_hazard_after", {31'd0, hazard1}, 32'h0);
      check("load8_count_after", {26'd0, busy_count}, 32'd0);

      // Reserve r8 in the same cycle its write retires: set wins
      reserve_valid = 1'b1;
      tick();
      reserve_valid = 1'b0;
      check("resv8b_count", {26'd0, busy_count}, 32'd1);
      req_valid = 3'b001;
      #1 check("load8b_ready", {29'd0, req_ready}, 32'h1);
      tick();
      req_valid = 3'b000;
      check("load8b_regwrite", {31'd0, RegWrite}, 32'h1);
      reserve_valid = 1'b1;
      #1 check("same_cycle_resv_ready", {31'd0, reserve_ready}, 32'h1);
      tick();
      reserve_valid = 1'b0;
      check("same_cycle_count", {26'd0, busy_count}, 32'd1);
      check("same_cycle_hazard1", {31'd0, hazard1}, 32'h1);

      // Reserve r0 is accepted but never marks busy
      reserve_valid = 1'b1; reserve_addr = 5'd0; Address1 = 5'd0;
      #1 check("resv0_ready", {31'd0, reserve_ready}, 32'h1);
      tick();
      reserve_valid = 1'b0;
      check("resv0_count", {26'd0, busy_count}, 32'd1);
      check("resv0_hazard1", {31'd0, hazard1}, 32'h0);
      check("resv0_hazard2", {31'd0, hazard2}, 32'h1);

      // Muldiv write to r0: accepted, no register file write (pointer 0)
      req_valid = 3'b010; req_addr[1] = 5'd0; req_data[1] = 32'h55;
      #1 check("r0_ready", {29'd0, req_ready}, 32'h2);
      tick();
      req_valid = 3'b111;
      check("r0_regwrite", {31'd0, RegWrite}, 32'h0);
      #1 check("r0_ptr_advanced", {29'd0, req_ready}, 32'h4);

      // Transfer, then reset on the following cycle
      req_valid = 3'b100; req_addr[2] = 5'd9; req_data[2] = 32'h99;
      #1 check("midrst_ready", {29'd0, req_ready}, 32'h4);
      tick();
      req_valid = 3'b111; rst = 1'b1;
      check("midrst_regwrite_t1", {31'd0, RegWrite}, 32'h1);
      #1 check("midrst_ready_in_rst", {29'd0, req_ready}, 32'h0);
      tick();
      rst = 1'b0;
      check("midrst_regwrite_t2", {31'd0, RegWrite}, 32'h0);
      check("midrst_count", {26'd0, busy_count}, 32'd0);
      check("midrst_hazard2", {31'd0, hazard2}, 32'h0);
      #1 check("midrst_ptr_reset", {29'd0, req_ready}, 32'h1);
      req_valid = 3'b000;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
